ahb_mem_arbiter2: RTL and testbench

//  Two-port AHB-Lite arbiter sharing one zero/low-wait memory slave (ROM/RAM) between two masters (e.g. CPU code bus + DMA).

---
 rtl/ahb_mem_arbiter2_if.sv | 23 ++
 rtl/ahb_mem_arbiter2.sv | 145 ++++++++++++++
 tb/tb_ahb_mem_arbiter2.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mem_arbiter2_if.sv
// AHB-Lite port bundle shared by the two upstream ports and the downstream memory port.
// The arbiter uses "slave" for the upstream ports and "master" for the downstream port.
interface ahb_mem_arbiter2_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb_mem_arbiter2.sv
// Two-port AHB-Lite arbiter in front of one low-wait memory slave.
// The losing address phase is parked in a one-entry register per port and replayed later.
module ahb_mem_arbiter2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahb_mem_arbiter2_if.slave  s0,
  ahb_mem_arbiter2_if.slave  s1,
  ahb_mem_arbiter2_if.master m,
  output logic [1:0]         GRANT
);

  typedef enum logic [1:0] {
    DP_NONE = 2'd0,
    DP_P0   = 2'd1,
    DP_P1   = 2'd2
  } dpOwner_t;

  logic [1:0]  r_pendValid;
  logic [31:0] r_pendAddr  [2];
  logic [1:0]  r_pendWrite;
  logic [2:0]  r_pendSize  [2];
  dpOwner_t    r_dpOwner;
  logic        r_lastGrant;

  logic [1:0]  w_live;
  logic [1:0]  w_req;
  logic [31:0] w_liveAddr  [2];
  logic [1:0]  w_liveWrite;
  logic [2:0]  w_liveSize  [2];
  logic        w_slot;
  logic        w_anyReq;
  logic        w_winner;
  logic        w_fwd;
  logic [31:0] w_addr;
  logic        w_write;
  logic [2:0]  w_size;

  // NONSEQ and SEQ both count as a live transfer; IDLE/BUSY never do.
  assign w_live[0] = s0.HSEL & ((s0.HTRANS == 2'b10) | (s0.HTRANS == 2'b11)) & s0.HREADY;
  assign w_live[1] = s1.HSEL & ((s1.HTRANS == 2'b10) | (s1.HTRANS == 2'b11)) & s1.HREADY;

  assign w_liveAddr[0]  = s0.HADDR;
  assign w_liveAddr[1]  = s1.HADDR;
  assign w_liveWrite[0] = s0.HWRITE;
  assign w_liveWrite[1] = s1.HWRITE;
  assign w_liveSize[0]  = s0.HSIZE;
  assign w_liveSize[1]  = s1.HSIZE;

  assign w_req    = r_pendValid | w_live;
  assign w_anyReq = |w_req;
  assign w_slot   = (r_dpOwner == DP_NONE) | m.HREADYOUT;
  assign w_fwd    = w_slot & w_anyReq & ~HRESET;

  always_comb begin
    w_winner = w_req[1];
    if (w_req == 2'b11) begin
      w_winner = FIXED_PRIO ? 1'b0 : ~r_lastGrant;
    end
  end

  // A parked address phase takes precedence over the live bus of the same port.
  always_comb begin
    w_addr  = w_liveAddr[w_winner];
    w_write = w_liveWrite[w_winner];
    w_size  = w_liveSize[w_winner];
    if (r_pendValid[w_winner]) begin
      w_addr  = r_pendAddr[w_winner];
      w_write = r_pendWrite[w_winner];
      w_size  = r_pendSize[w_winner];
    end
  end

  assign m.HSEL   = w_fwd;
  assign m.HTRANS = w_fwd ? 2'b10 : 2'b00;
  assign m.HADDR  = w_fwd ? w_addr : 32'd0;
  assign m.HWRITE = w_fwd ? w_write : 1'b0;
  assign m.HSIZE  = w_fwd ? w_size : 3'd0;
  assign m.HREADY = (r_dpOwner == DP_NONE) ? 1'b1 : m.HREADYOUT;
  assign GRANT    = w_fwd ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    case (r_dpOwner)
      DP_P0:   m.HWDATA = s0.HWDATA;
      DP_P1:   m.HWDATA = s1.HWDATA;
      default: m.HWDATA = 32'd0;
    endcase
  end

  always_comb begin
    s0.HREADYOUT = 1'b1;
    s1.HREADYOUT = 1'b1;
    if (!HRESET) begin
      if (r_dpOwner == DP_P0) begin
        s0.HREADYOUT = m.HREADYOUT;
      end else if (r_pendValid[0]) begin
        s0.HREADYOUT = 1'b0;
      end
      if (r_dpOwner == DP_P1) begin
        s1.HREADYOUT = m.HREADYOUT;
      end else if (r_pendValid[1]) begin
        s1.HREADYOUT = 1'b0;
      end
    end
  end

  assign s0.HRDATA = (!HRESET && (r_dpOwner == DP_P0)) ? m.HRDATA : 32'd0;
  assign s1.HRDATA = (!HRESET && (r_dpOwner == DP_P1)) ? m.HRDATA : 32'd0;

  // A live request that is not forwarded this cycle is parked; reset drops it without replay.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pendValid <= 2'b00;
      r_dpOwner   <= DP_NONE;
      r_lastGrant <= 1'b1;
    end else begin
      if (w_slot) begin
        if (w_anyReq) begin
          r_dpOwner   <= w_winner ? DP_P1 : DP_P0;
          r_lastGrant <= w_winner;
        end else begin
          r_dpOwner <= DP_NONE;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (w_fwd && (w_winner == 1'(i))) begin
          r_pendValid[i] <= 1'b0;
        end else if (w_live[i]) begin
          r_pendValid[i] <= 1'b1;
          r_pendAddr[i]  <= w_liveAddr[i];
          r_pendWrite[i] <= w_liveWrite[i];
          r_pendSize[i]  <= w_liveSize[i];
        end
      end
    end
  end

  // A stalled port sees HREADY low, so it can never present a new transfer while parked.
  aPendLive0 : assert property (@(posedge HCLK) disable iff (HRESET)
                                !(r_pendValid[0] && w_live[0]));
  aPendLive1 : assert property (@(posedge HCLK) disable iff (HRESET)
                                !(r_pendValid[1] && w_live[1]));

endmodule

// File: tb/tb_ahb_mem_arbiter2.sv
// Directed bench for ahb_mem_arbiter2: round-robin instance plus a fixed-priority instance
// sharing the same stimulus; each port's bus HREADY is looped back from its HREADYOUT.
module tb_ahb_mem_arbiter2;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        s0Sel, s1Sel;
  logic [31:0] s0Addr, s1Addr;
  logic [1:0]  s0Trans, s1Trans;
  logic        s0Write, s1Write;
  logic [2:0]  s0Size, s1Size;
  logic [31:0] s0Wdata, s1Wdata;
  logic        mReadyOut;
  logic [31:0] mRdata;
  logic [1:0]  grantRr, grantFp;
  int          checks = 0;
  int          failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_mem_arbiter2_if s0Rr ();
  ahb_mem_arbiter2_if s1Rr ();
  ahb_mem_arbiter2_if mRr ();
  ahb_mem_arbiter2_if s0Fp ();
  ahb_mem_arbiter2_if s1Fp ();
  ahb_mem_arbiter2_if mFp ();

  assign s0Rr.HSEL = s0Sel;     assign s0Fp.HSEL = s0Sel;
  assign s0Rr.HADDR = s0Addr;   assign s0Fp.HADDR = s0Addr;
  assign s0Rr.HTRANS = s0Trans; assign s0Fp.HTRANS = s0Trans;
  assign s0Rr.HWRITE = s0Write; assign s0Fp.HWRITE = s0Write;
  assign s0Rr.HSIZE = s0Size;   assign s0Fp.HSIZE = s0Size;
  assign s0Rr.HWDATA = s0Wdata; assign s0Fp.HWDATA = s0Wdata;
  assign s0Rr.HREADY = s0Rr.HREADYOUT;
  assign s0Fp.HREADY = s0Fp.HREADYOUT;

  assign s1Rr.HSEL = s1Sel;     assign s1Fp.HSEL = s1Sel;
  assign s1Rr.HADDR = s1Addr;   assign s1Fp.HADDR = s1Addr;
  assign s1Rr.HTRANS = s1Trans; assign s1Fp.HTRANS = s1Trans;
  assign s1Rr.HWRITE = s1Write; assign s1Fp.HWRITE = s1Write;
  assign s1Rr.HSIZE = s1Size;   assign s1Fp.HSIZE = s1Size;
  assign s1Rr.HWDATA = s1Wdata; assign s1Fp.HWDATA = s1Wdata;
  assign s1Rr.HREADY = s1Rr.HREADYOUT;
  assign s1Fp.HREADY = s1Fp.HREADYOUT;

  assign mRr.HREADYOUT = mReadyOut; assign mFp.HREADYOUT = mReadyOut;
  assign mRr.HRDATA = mRdata;       assign mFp.HRDATA = mRdata;

  ahb_mem_arbiter2 #(.FIXED_PRIO(1'b0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .s0(s0Rr), .s1(s1Rr), .m(mRr), .GRANT(grantRr)
  );

  ahb_mem_arbiter2 #(.FIXED_PRIO(1'b1)) dutFp (
    .HCLK(HCLK), .HRESET(HRESET), .s0(s0Fp), .s1(s1Fp), .m(mFp), .GRANT(grantFp)
  );

  task automatic applyStimulus(input int port, input logic sel, input logic [31:0] addr,
                               input logic [1:0] trans, input logic write,
                               input logic [2:0] size, input logic [31:0] wdata);
    if (port == 0) begin
      s0Sel = sel; s0Addr = addr; s0Trans = trans; s0Write = write; s0Size = size; s0Wdata = wdata;
    end else begin
      s1Sel = sel; s1Addr = addr; s1Trans = trans; s1Write = write; s1Size = size; s1Wdata = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idleBoth;
    applyStimulus(0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    applyStimulus(1, 1'b0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
  endtask

  task automatic resetPulse;
    nextCycle;
    HRESET = 1'b1;
    idleBoth;
    nextCycle;
    HRESET = 1'b0;
  endtask

  initial begin
    idleBoth;
    mReadyOut = 1'b1;
    mRdata = 32'h55AA55AA;

    // Reset forces outputs even with a live request present
    nextCycle;
    nextCycle;
    applyStimulus(0, 1'b1, 32'h100, 2'b10, 1'b0, 3'd2, 32'h0);
    #1;
    checkOutput("rst_s0_ready", 32'(s0Rr.HREADYOUT), 32'h1);
    checkOutput("rst_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    checkOutput("rst_s0_rdata", s0Rr.HRDATA, 32'h0);
    checkOutput("rst_m_hsel", 32'(mRr.HSEL), 32'h0);
    checkOutput("rst_m_htrans", 32'(mRr.HTRANS), 32'h0);
    checkOutput("rst_grant", 32'(grantRr), 32'h0);

    // Test 1: uncontended read forwarded in the same cycle
    nextCycle;
    HRESET = 1'b0;
    #1;
    checkOutput("t1_m_haddr", mRr.HADDR, 32'h100);
    checkOutput("t1_m_htrans", 32'(mRr.HTRANS), 32'h2);
    checkOutput("t1_grant", 32'(grantRr), 32'h1);
    nextCycle;
    applyStimulus(0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    mRdata = 32'h11112222;
    #1;
    checkOutput("t1_s0_ready", 32'(s0Rr.HREADYOUT), 32'h1);
    checkOutput("t1_s0_rdata", s0Rr.HRDATA, 32'h11112222);
    checkOutput("t1_s1_rdata", s1Rr.HRDATA, 32'h0);
    checkOutput("t1_idle_grant", 32'(grantRr), 32'h0);

    // Test 2: post-reset tie, port1 write is parked and replayed
    resetPulse;
    applyStimulus(0, 1'b1, 32'h10, 2'b10, 1'b0, 3'd1, 32'h12345678);
    applyStimulus(1, 1'b1, 32'h20, 2'b10, 1'b1, 3'd2, 32'hDEADBEEF);
    #1;
    checkOutput("t2_c0_grant", 32'(grantRr), 32'h1);
    checkOutput("t2_c0_haddr", mRr.HADDR, 32'h10);
    checkOutput("t2_c0_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    nextCycle;
    applyStimulus(0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd1, 32'h12345678);
    applyStimulus(1, 1'b0, 32'h0, 2'b00, 1'b0, 3'd2, 32'hDEADBEEF);
    mRdata = 32'hCAFE0010;
    #1;
    checkOutput("t2_c1_grant", 32'(grantRr), 32'h2);
    checkOutput("t2_c1_haddr", mRr.HADDR, 32'h20);
    checkOutput("t2_c1_hwrite", 32'(mRr.HWRITE), 32'h1);
    checkOutput("t2_c1_hsize", 32'(mRr.HSIZE), 32'h2);
    checkOutput("t2_c1_s1_ready", 32'(s1Rr.HREADYOUT), 32'h0);
    checkOutput("t2_c1_s0_rdata", s0Rr.HRDATA, 32'hCAFE0010);
    checkOutput("t2_c1_hwdata", mRr.HWDATA, 32'h12345678);
    nextCycle;
    #1;
    checkOutput("t2_c2_hwdata", mRr.HWDATA, 32'hDEADBEEF);
    checkOutput("t2_c2_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    checkOutput("t2_c2_grant", 32'(grantRr), 32'h0);
    checkOutput("t2_c2_s0_rdata", s0Rr.HRDATA, 32'h0);

    // Test 3: both ports request every cycle
    resetPulse;
    applyStimulus(0, 1'b1, 32'h200, 2'b10, 1'b0, 3'd2, 32'h0);
    applyStimulus(1, 1'b1, 32'h300, 2'b10, 1'b0, 3'd2, 32'h0);
    #1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3_rr_grant_%0d", i), 32'(grantRr), (i % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("t3_rr_haddr_%0d", i), mRr.HADDR, (i % 2 == 0) ? 32'h200 : 32'h300);
      checkOutput($sformatf("t3_fp_grant_%0d", i), 32'(grantFp), 32'h1);
      if (i == 7) begin
        checkOutput("t3_fp_s1_starved", 32'(s1Fp.HREADYOUT), 32'h0);
      end
      nextCycle;
      #1;
    end
    idleBoth;
    #1;
    checkOutput("t3_rr_drain", 32'(grantRr), 32'h1);
    checkOutput("t3_fp_drain", 32'(grantFp), 32'h2);

    // Test 4: slave stall while port1 issues 0x40
    resetPulse;
    applyStimulus(0, 1'b1, 32'h30, 2'b10, 1'b0, 3'd2, 32'h0);
    #1;
    checkOutput("t4_c0_grant", 32'(grantRr), 32'h1);
    nextCycle;
    applyStimulus(0, 1'b0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    applyStimulus(1, 1'b1, 32'h40, 2'b10, 1'b0, 3'd2, 32'h0);
    mReadyOut = 1'b0;
    #1;
    checkOutput("t4_c1_htrans", 32'(mRr.HTRANS), 32'h0);
    checkOutput("t4_c1_grant", 32'(grantRr), 32'h0);
    checkOutput("t4_c1_s0_ready", 32'(s0Rr.HREADYOUT), 32'h0);
    checkOutput("t4_c1_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    checkOutput("t4_c1_m_hready", 32'(mRr.HREADY), 32'h0);
    nextCycle;
    applyStimulus(1, 1'b0, 32'h0, 2'b00, 1'b0, 3'd2, 32'h0);
    #1;
    checkOutput("t4_c2_s1_ready", 32'(s1Rr.HREADYOUT), 32'h0);
    checkOutput("t4_c2_htrans", 32'(mRr.HTRANS), 32'h0);
    checkOutput("t4_c2_hsel", 32'(mRr.HSEL), 32'h0);
    nextCycle;
    mReadyOut = 1'b1;
    mRdata = 32'h30303030;
    #1;
    checkOutput("t4_c3_grant", 32'(grantRr), 32'h2);
    checkOutput("t4_c3_haddr", mRr.HADDR, 32'h40);
    checkOutput("t4_c3_htrans", 32'(mRr.HTRANS), 32'h2);
    checkOutput("t4_c3_s0_rdata", s0Rr.HRDATA, 32'h30303030);
    checkOutput("t4_c3_s1_ready", 32'(s1Rr.HREADYOUT), 32'h0);
    nextCycle;
    mRdata = 32'h40404040;
    #1;
    checkOutput("t4_c4_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    checkOutput("t4_c4_s1_rdata", s1Rr.HRDATA, 32'h40404040);
    checkOutput("t4_c4_grant", 32'(grantRr), 32'h0);

    // Test 5: reset while port1 has a parked transfer
    resetPulse;
    applyStimulus(0, 1'b1, 32'h50, 2'b10, 1'b0, 3'd2, 32'h0);
    applyStimulus(1, 1'b1, 32'h58, 2'b10, 1'b0, 3'd2, 32'h0);
    #1;
    checkOutput("t5_c0_grant", 32'(grantRr), 32'h1);
    nextCycle;
    idleBoth;
    HRESET = 1'b1;
    #1;
    checkOutput("t5_rst_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    checkOutput("t5_rst_grant", 32'(grantRr), 32'h0);
    checkOutput("t5_rst_htrans", 32'(mRr.HTRANS), 32'h0);
    nextCycle;
    HRESET = 1'b0;
    mReadyOut = 1'b0;
    #1;
    checkOutput("t5_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    checkOutput("t5_s0_ready_none", 32'(s0Rr.HREADYOUT), 32'h1);
    checkOutput("t5_m_hready_none", 32'(mRr.HREADY), 32'h1);
    checkOutput("t5_grant", 32'(grantRr), 32'h0);
    checkOutput("t5_htrans", 32'(mRr.HTRANS), 32'h0);
    nextCycle;
    mReadyOut = 1'b1;
    #1;
    checkOutput("t5_no_replay", 32'(grantRr), 32'h0);

    // Test 6: IDLE/BUSY and unselected requests are ignored; SEQ is demoted to NONSEQ
    resetPulse;
    applyStimulus(0, 1'b1, 32'h60, 2'b00, 1'b0, 3'd2, 32'h0);
    applyStimulus(1, 1'b0, 32'h70, 2'b10, 1'b0, 3'd2, 32'h0);
    #1;
    checkOutput("t6_grant", 32'(grantRr), 32'h0);
    checkOutput("t6_htrans", 32'(mRr.HTRANS), 32'h0);
    checkOutput("t6_hsel", 32'(mRr.HSEL), 32'h0);
    checkOutput("t6_s0_ready", 32'(s0Rr.HREADYOUT), 32'h1);
    checkOutput("t6_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    nextCycle;
    applyStimulus(0, 1'b1, 32'h64, 2'b01, 1'b0, 3'd2, 32'h0);
    #1;
    checkOutput("t6_busy_grant", 32'(grantRr), 32'h0);
    checkOutput("t6_busy_s1_ready", 32'(s1Rr.HREADYOUT), 32'h1);
    nextCycle;
    applyStimulus(0, 1'b1, 32'h80, 2'b11, 1'b0, 3'd2, 32'h0);
    #1;
    checkOutput("t6_seq_htrans", 32'(mRr.HTRANS), 32'h2);
    checkOutput("t6_seq_haddr", mRr.HADDR, 32'h80);
    checkOutput("t6_seq_grant", 32'(grantRr), 32'h1);
    nextCycle;
    idleBoth;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
